// File: rtl/serial_twos_unit.sv
// Digit-serial two's-complement unit: negate, absolute value, sign-magnitude conversion or pass.
// Latency: WIDTH/DIGIT cycles from accept to out_valid; holds the result in DONE until out_ready.
module serial_twos_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] res_shift;
    logic             is_min;
    logic             cap_inv;
    logic [WIDTH-1:0] cap_op;

    assign digit_sum = {1'b0, (op_q[DIGIT-1:0] ^ {DIGIT{inv_q}})} + {{DIGIT{1'b0}}, carry_q};
    assign is_min    = (a == {1'b1, {(WIDTH-1){1'b0}}});

    // Result digits enter at the top so the LSB digit lands at bit 0 after N cycles.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign res_shift = digit_sum[DIGIT-1:0];
        end else begin : g_part
            assign res_shift = {digit_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        inv_d     = inv_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        cap_inv   = 1'b0;
        cap_op    = a;
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);

        case (mode)
            2'b00:   cap_inv = 1'b1;
            2'b01:   cap_inv = a[WIDTH-1];
            2'b10: begin
                cap_inv = a[WIDTH-1];
                cap_op  = {1'b0, a[WIDTH-2:0]};
            end
            default: cap_inv = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d    = cap_op;
                    inv_d   = cap_inv;
                    carry_d = cap_inv;
                    // The minimum value negates to itself, so only the flag needs computing.
                    ovf_d   = (mode == 2'b00 || mode == 2'b01) && is_min;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                op_d    = op_q >> DIGIT;
                res_d   = res_shift;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    zero_d  = (res_shift == '0);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = res_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_twos_unit.sv
// Bench for serial_twos_unit: directed table plus hand sequences for backpressure and mid-run reset,
// on a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4) instance.
module tb_serial_twos_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, ovf8, zero8;
    logic [7:0] a8, result8;
    logic [1:0] mode8;
    logic       in_valid4, in_ready4, out_valid4, out_ready4, ovf4, zero4;
    logic [7:0] a4, result4;
    logic [1:0] mode4;

    logic       sel;
    logic       cur_vld, cur_rdy, cur_ovf, cur_zero;
    logic [7:0] cur_res;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    serial_twos_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .ovf(ovf8), .zero(zero8)
    );

    serial_twos_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
        .result(result4), .ovf(ovf4), .zero(zero4)
    );

    assign cur_vld  = sel ? out_valid4 : out_valid8;
    assign cur_rdy  = sel ? in_ready4  : in_ready8;
    assign cur_res  = sel ? result4    : result8;
    assign cur_ovf  = sel ? ovf4       : ovf8;
    assign cur_zero = sel ? zero4      : zero8;

    typedef struct {
        logic       s;
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] r;
        logic       o;
        logic       z;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [9:0] ref_op(input logic [1:0] m, input logic [7:0] x);
        logic [7:0] r;
        logic       o;
        case (m)
            2'd0: begin r = 8'd0 - x; o = (x == 8'h80); end
            2'd1: begin r = x[7] ? 8'd0 - x : x; o = (x == 8'h80); end
            2'd2: begin r = x[7] ? 8'd0 - {1'b0, x[6:0]} : x; o = 1'b0; end
            default: begin r = x; o = 1'b0; end
        endcase
        return {o, (r == 8'd0), r};
    endfunction

    task automatic drive(input logic s, input logic v, input logic [1:0] m, input logic [7:0] av);
        if (s) begin in_valid4 = v; mode4 = m; a4 = av; end
        else   begin in_valid8 = v; mode8 = m; a8 = av; end
    endtask

    task automatic do_op(input logic s, input logic [1:0] m, input logic [7:0] av,
                         input logic [7:0] er, input logic eo, input logic ez, input string nm);
        int lat;
        sel = s;
        @(negedge clk);
        drive(s, 1'b1, m, av);
        #1 chk({nm, ".in_ready"}, cur_rdy, 1);
        @(posedge clk);
        #1 drive(s, 1'b0, ~m, ~av);
        lat = 0;
        while (!cur_vld && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({nm, ".latency"}, lat, s ? 2 : 8);
        chk({nm, ".result"}, cur_res, er);
        chk({nm, ".ovf"}, cur_ovf, eo);
        chk({nm, ".zero"}, cur_zero, ez);
        @(posedge clk);
        #1 chk({nm, ".drained"}, cur_vld, 0);
    endtask

    initial begin
        logic [9:0] exp;
        logic [1:0] rm;
        logic [7:0] ra;
        int         lat;

        vecs[0]  = '{1'b0, 2'd0, 8'h05, 8'hFB, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd1, 8'h9C, 8'h64, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 8'h37, 8'h37, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 8'h85, 8'hFB, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'd3, 8'hA5, 8'hA5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'd2, 8'h05, 8'h05, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 8'h01, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 8'h05, 8'hFB, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'd1, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 2'd2, 8'h80, 8'h00, 1'b0, 1'b1};

        sel = 1'b0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = 8'h00; mode8 = 2'd0; out_ready8 = 1'b1;
        in_valid4 = 1'b0; a4 = 8'h00; mode4 = 2'd0; out_ready4 = 1'b1;

        #3;
        chk("rst.in_ready8", in_ready8, 0);
        chk("rst.out_valid8", out_valid8, 0);
        chk("rst.result8", result8, 0);
        chk("rst.ovf8", ovf8, 0);
        chk("rst.zero8", zero8, 0);
        chk("rst.in_ready4", in_ready4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.release_ready", in_ready8, 1);

        for (int i = 0; i < 16; i++)
            do_op(vecs[i].s, vecs[i].m, vecs[i].a, vecs[i].r, vecs[i].o, vecs[i].z,
                  $sformatf("vec%0d", i));

        // Backpressure in DONE with noisy inputs
        sel = 1'b0;
        out_ready8 = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd1, 8'h9C);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 2'd1, 8'h00);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp.latency", lat, 8);
        chk("bp.result", result8, 8'h64);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, i[0] ? 1'b0 : 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            @(posedge clk);
            #1;
            chk($sformatf("bp.hold_res%0d", i), result8, 8'h64);
            chk($sformatf("bp.hold_vld%0d", i), out_valid8, 1);
            chk($sformatf("bp.hold_rdy%0d", i), in_ready8, 0);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        drive(1'b0, 1'b1, 2'd0, 8'h05);
        @(posedge clk);
        #1;
        chk("bp.xfer_vld", out_valid8, 0);
        chk("bp.no_reaccept", in_ready8, 1);
        drive(1'b0, 1'b0, 2'd0, 8'h05);
        @(posedge clk);
        #1;
        chk("bp.single_xfer", out_valid8, 0);
        chk("bp.idle_ready", in_ready8, 1);

        // Reset in the middle of a bit-serial negate
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd0, 8'h05);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 2'd0, 8'h05);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.vld", out_valid8, 0);
        chk("mid.rdy", in_ready8, 0);
        chk("mid.result", result8, 0);
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("mid.hold_vld", out_valid8, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid.release_rdy", in_ready8, 1);
        do_op(1'b0, 2'd0, 8'h01, 8'hFF, 1'b0, 1'b0, "mid.neg01");

        // Random compare against the reference model on both instances
        for (int i = 0; i < 30; i++) begin
            rm  = 2'($urandom_range(0, 3));
            ra  = 8'($urandom_range(0, 255));
            exp = ref_op(rm, ra);
            do_op(i[0], rm, ra, exp[7:0], exp[9], exp[8], $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
